wb_queue: RTL and testbench

Writeback queue sitting directly upstream of the register file write port (`wp`/`we`/`din`). It accepts results from the ALU and load/store paths, buffers them in a small in-order FIFO, and retires one write per cycle into the register file. It also exposes a pending-write scoreboard so decode can stall on read-after-write hazards. It filters writes to reserved register numbers, because the register file drives registers 15 and 20 itself.

---
 rtl/wb_queue.sv | 139 +++++++++++++
 tb/tb_wb_queue.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/wb_queue.sv
// wb_queue: in-order writeback FIFO in front of the register file write port.
// Accepts ALU and load results, drops writes to reserved register numbers,
// retires one write per cycle and exposes a pending-write scoreboard for decode.
module wb_queue #(
    parameter int DEPTH = 4,
    parameter int NREGS = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    output logic [4:0]  wp,
    output logic        we,
    output logic [31:0] din,
    input  logic [4:0]  qa,
    input  logic [4:0]  qb,
    output logic        busy_a,
    output logic        busy_b,
    output logic [7:0]  drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // FIFO storage and control state
    logic [4:0]    r_ent_rd   [DEPTH];
    logic [31:0]   r_ent_data [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [7:0]    r_drop_cnt;

    // Handshake / enqueue decisions for this cycle
    logic          w_alu_ready;
    logic          w_alu_acc;
    logic          w_alu_enq;
    logic          w_alu_drop;
    logic [CW-1:0] w_cnt_alu;
    logic          w_mem_ready;
    logic          w_mem_acc;
    logic          w_mem_enq;
    logic          w_mem_drop;
    logic          w_pop;
    logic [AW-1:0] w_mem_idx;
    logic [CW-1:0] w_count_next;
    logic [8:0]    w_drop_sum;
    logic [AW-1:0] w_sb_idx;
    logic          w_busy_a;
    logic          w_busy_b;

    // Registers 15 and 20 are owned by the register file itself; 0 is never written.
    function automatic logic legal_rd(input logic [4:0] rd);
        return (rd != 5'd0) && (int'(rd) <= NREGS) && (rd != 5'd15) && (rd != 5'd20);
    endfunction

    // Readiness is computed from the current count only; a same-cycle pop is not credited.
    always_comb begin
        w_alu_ready  = (r_count < DEPTH_C);
        w_alu_acc    = alu_valid & w_alu_ready;
        w_alu_enq    = w_alu_acc & legal_rd(alu_rd);
        w_alu_drop   = w_alu_acc & ~legal_rd(alu_rd);
        w_cnt_alu    = r_count + CW'(w_alu_enq);
        w_mem_ready  = (w_cnt_alu < DEPTH_C);
        w_mem_acc    = mem_valid & w_mem_ready;
        w_mem_enq    = w_mem_acc & legal_rd(mem_rd);
        w_mem_drop   = w_mem_acc & ~legal_rd(mem_rd);
        w_pop        = (r_count != '0);
        // The mem entry lands behind the ALU entry so it retires later and wins on equal rd.
        w_mem_idx    = r_wr_ptr + AW'(w_alu_enq);
        w_count_next = r_count + CW'(w_alu_enq) + CW'(w_mem_enq) - CW'(w_pop);
        w_drop_sum   = {1'b0, r_drop_cnt} + 9'(w_alu_drop) + 9'(w_mem_drop);
    end

    // Scoreboard: any valid entry (head included) targeting the queried register.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
        w_busy_a = 1'b0;
        w_busy_b = 1'b0;
        w_sb_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_sb_idx = r_rd_ptr + AW'(i);
            if (CW'(i) < r_count) begin
                if (r_ent_rd[w_sb_idx] == qa) w_busy_a = 1'b1;
                if (r_ent_rd[w_sb_idx] == qb) w_busy_b = 1'b1;
            end
        end
        if (qa == 5'd0) w_busy_a = 1'b0;
        if (qb == 5'd0) w_busy_b = 1'b0;
    end

    // Entry payload writes; contents are qualified by count so they need no reset.
    always_ff @(posedge clk) begin
        // NOTE: storage arrays are left unreset; only pointers and count define validity.
        if (!rst) begin
            if (w_alu_enq) begin
                r_ent_rd[r_wr_ptr]   <= alu_rd;
                r_ent_data[r_wr_ptr] <= alu_data;
            end
            if (w_mem_enq) begin
                r_ent_rd[w_mem_idx]   <= mem_rd;
                r_ent_data[w_mem_idx] <= mem_data;
            end
        end
    end

    // Pointer, occupancy and drop-counter update; reset flushes everything pending.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_rd_ptr   <= r_rd_ptr + AW'(w_pop);
            r_wr_ptr   <= r_wr_ptr + AW'(w_alu_enq) + AW'(w_mem_enq);
            r_count    <= w_count_next;
            r_drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
        end
    end

    // Retire port: head entry when non-empty, all zero when idle so wp never points at a register.
    assign we        = w_pop;
    assign wp        = w_pop ? r_ent_rd[r_rd_ptr]   : 5'd0;
    assign din       = w_pop ? r_ent_data[r_rd_ptr] : 32'd0;
    assign alu_ready = w_alu_ready;
    assign mem_ready = w_mem_ready;
    assign busy_a    = w_busy_a;
    assign busy_b    = w_busy_b;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: directed and random stimulus against a queue-based reference model.
module tb_wb_queue;

    localparam int DEPTH = 4;
    localparam int NREGS = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic [4:0]  wp;
    logic        we;
    logic [31:0] din;
    logic [4:0]  qa;
    logic [4:0]  qb;
    logic        busy_a;
    logic        busy_b;
    logic [7:0]  drop_cnt;

    wb_queue #(.DEPTH(DEPTH), .NREGS(NREGS)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .wp(wp), .we(we), .din(din),
        .qa(qa), .qb(qb), .busy_a(busy_a), .busy_b(busy_b),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t q[$];
    int   model_drop = 0;
    int   n_checks   = 0;
    int   n_fail     = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [4:0] rd);
        int r = int'(rd);
        return r >= 1 && r <= NREGS && r != 15 && r != 20;
    endfunction

    function automatic bit pending(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        foreach (q[i]) if (q[i].rd == r) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: drive inputs, compare outputs mid-cycle, then advance the model at the edge.
    task automatic cyc(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                       input bit mv, input logic [4:0] mrd, input logic [31:0] md,
                       input bit r, input logic [4:0] a_q, input logic [4:0] b_q);
        int sz;
        bit a_rdy, a_acc, a_enq, m_rdy, m_acc, m_enq;
        ent_t e;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        rst = r; qa = a_q; qb = b_q;
        @(negedge clk);
        sz    = q.size();
        a_rdy = sz < DEPTH;
        a_acc = av && a_rdy;
        a_enq = a_acc && legal(ard);
        m_rdy = (sz + int'(a_enq)) < DEPTH;
        m_acc = mv && m_rdy;
        m_enq = m_acc && legal(mrd);
        check("alu_ready", 64'(alu_ready), 64'(a_rdy));
        check("mem_ready", 64'(mem_ready), 64'(m_rdy));
        check("we", 64'(we), 64'(sz != 0));
        check("wp", 64'(wp), sz != 0 ? 64'(q[0].rd) : 64'd0);
        check("din", 64'(din), sz != 0 ? 64'(q[0].data) : 64'd0);
        check("busy_a", 64'(busy_a), 64'(pending(a_q)));
        check("busy_b", 64'(busy_b), 64'(pending(b_q)));
        check("drop_cnt", 64'(drop_cnt), 64'(model_drop));
        check("count", 64'(dut.r_count), 64'(sz));
        @(posedge clk);
        if (r) begin
            q.delete();
            model_drop = 0;
        end else begin
            if (sz != 0) void'(q.pop_front());
            if (a_enq) begin e.rd = ard; e.data = ad; q.push_back(e); end
            if (m_enq) begin e.rd = mrd; e.data = md; q.push_back(e); end
            model_drop += int'(a_acc && !a_enq) + int'(m_acc && !m_enq);
            if (model_drop > 255) model_drop = 255;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 5'd3, 5'd5);
    endtask

    initial begin
        logic [4:0] bad_rd [4];
        bad_rd[0] = 5'd0; bad_rd[1] = 5'd15; bad_rd[2] = 5'd20; bad_rd[3] = 5'd25;
        rst = 1'b1; alu_valid = 0; alu_rd = 0; alu_data = 0;
        mem_valid = 0; mem_rd = 0; mem_data = 0; qa = 0; qb = 0;
        @(posedge clk); #1;
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(5);

        // Single ALU write to rd 3
        cyc(1, 5'd3, 32'hDEADBEEF, 0, 0, 0, 0, 5'd3, 5'd0);
        idle(2);

        // Same-cycle double enqueue to rd 5
        cyc(1, 5'd5, 32'd1, 1, 5'd5, 32'd2, 0, 5'd5, 5'd5);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, 5'd5, 5'd1);

        // Both sources continuously valid for 10 cycles
        for (int i = 0; i < 10; i++)
            cyc(1, 5'(1 + i % 14), 32'h100 + i, 1, 5'(2 + i % 12), 32'h200 + i, 0,
                5'(1 + i % 14), 5'(2 + i % 12));
        idle(6);

        // Reserved and out-of-range destinations are discarded
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, bad_rd[i], 32'hBAD0 + i, 0, 0, 0, 0, bad_rd[i], 0);
        check("drop_four", 64'(drop_cnt), 64'd4);
        for (int i = 0; i < 150; i++) cyc(1, 5'd0, 0, 1, 5'd31, 0, 0, 0, 0);
        check("drop_sat", 64'(drop_cnt), 64'd255);

        // Fill, then reset flushes pending writes
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc(1, 5'd7, 32'hA1, 1, 5'd8, 32'hA2, 0, 5'd7, 5'd8);
        cyc(1, 5'd9, 32'hA3, 1, 5'd10, 32'hA4, 0, 5'd9, 5'd10);
        check("fill_count", 64'(dut.r_count), 64'd3);
        cyc(0, 0, 0, 0, 0, 0, 1, 5'd9, 5'd10);
        check("flush_we", 64'(we), 64'd0);
        idle(5);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] ra, rm, xa, xb;
            ra = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 12));
            rm = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 12));
            xa = 5'($urandom_range(0, 13));
            xb = 5'($urandom_range(0, 21));
            cyc($urandom_range(0, 2) != 0, ra, $urandom, $urandom_range(0, 2) != 0, rm, $urandom,
                $urandom_range(0, 60) == 0, xa, xb);
        end
        idle(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
